kernel_d_vin_feeder: RTL and testbench

// - Upstream feeder for the kernel_D pipeline top: accepts a valid/ready input

---
 rtl/kernel_d_vin_feeder.sv | 137 +++++++++++++
 tb/tb_kernel_d_vin_feeder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_d_vin_feeder.sv
// kernel_d_vin_feeder
//   Upstream feeder for the kernel_D pipeline. It accepts a valid/ready input
//   stream and buffers it in a show-ahead FIFO. It presents at most one word
//   per cycle on kd_vin and counts NELEM words per run (start -> done).
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous, active-low reset
//   start     : one-cycle pulse, begins a run when idle
//   in_valid  : input word valid
//   in_data   : input word
//   in_ready  : feeder accepts in_data this cycle
//   ds_stall  : downstream full, freezes feeding
//   kd_vin    : word to kernel_D, zero whenever stall is high
//   stall     : kernel_D stall, low only on a cycle a word is consumed
//   done      : one-cycle pulse after the last word of a run is fed
//   fed_cnt   : words fed to the kernel in the current run
module kernel_d_vin_feeder #(
    parameter int DATAW = 32,
    parameter int DEPTH = 16,
    parameter int NELEM = 1024,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    input  logic             ds_stall,
    output logic [DATAW-1:0] kd_vin,
    output logic             stall,
    output logic             done,
    output logic [CNTW-1:0]  fed_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNTW-1:0] NELEM_C = CNTW'(NELEM);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);

    logic [1:0]       state_q, state_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  in_cnt_q, in_cnt_d;
    logic [CNTW-1:0]  fed_cnt_q, fed_cnt_d;
    logic [DATAW-1:0] mem_q [DEPTH];

    logic running;
    logic empty;
    logic full;
    logic ready_c;
    logic push;
    logic pop;

    // Pointers carry one extra wrap bit. The pointers are equal when the FIFO
    // is empty. They differ only in the wrap bit when the FIFO is full.
    always_comb begin
        running = (state_q == S_RUN);
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // Depends only on registered state, never on in_valid
        ready_c = running && !full && (in_cnt_q < NELEM_C);
        push    = in_valid && ready_c;
        pop     = running && !empty && !ds_stall;
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        in_cnt_d  = in_cnt_q;
        fed_cnt_d = fed_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            in_cnt_d = in_cnt_q + CNT_ONE;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            fed_cnt_d = fed_cnt_q + CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    in_cnt_d  = '0;
                    fed_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (pop && (fed_cnt_q + CNT_ONE == NELEM_C)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            in_cnt_q  <= '0;
            fed_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            in_cnt_q  <= in_cnt_d;
            fed_cnt_q <= fed_cnt_d;
        end
    end

    // Storage has no reset. Clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    assign in_ready = ready_c;
    assign stall    = !pop;
    assign kd_vin   = pop ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign done     = (state_q == S_DONE);
    assign fed_cnt  = fed_cnt_q;

endmodule

// File: tb/tb_kernel_d_vin_feeder.sv
module tb_kernel_d_vin_feeder;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a, in_valid_a, ds_stall_a, in_ready_a, stall_a, done_a;
    logic [31:0] in_data_a, kd_vin_a;
    logic [15:0] fed_cnt_a;

    logic        start_b, in_valid_b, ds_stall_b, in_ready_b, stall_b, done_b;
    logic [31:0] in_data_b, kd_vin_b;
    logic [15:0] fed_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    kernel_d_vin_feeder #(.DATAW(32), .DEPTH(4), .NELEM(8), .CNTW(16)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a),
        .in_data(in_data_a), .in_ready(in_ready_a), .ds_stall(ds_stall_a),
        .kd_vin(kd_vin_a), .stall(stall_a), .done(done_a), .fed_cnt(fed_cnt_a)
    );

    kernel_d_vin_feeder #(.DATAW(32), .DEPTH(16), .NELEM(20), .CNTW(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b),
        .in_data(in_data_b), .in_ready(in_ready_b), .ds_stall(ds_stall_b),
        .kd_vin(kd_vin_b), .stall(stall_b), .done(done_b), .fed_cnt(fed_cnt_b)
    );

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        in_valid;
        logic [31:0] in_data;
        logic        ds_stall;
        logic        exp_ready;
        logic        exp_stall;
        logic [31:0] exp_kd;
        logic        exp_done;
        logic [15:0] exp_fed;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic r, input logic s, input logic v,
                                input logic [31:0] d, input logic ds,
                                input logic er, input logic es,
                                input logic [31:0] ek, input logic ed,
                                input logic [15:0] ef);
        vec_t x;
        x.rst_n = r; x.start = s; x.in_valid = v; x.in_data = d; x.ds_stall = ds;
        x.exp_ready = er; x.exp_stall = es; x.exp_kd = ek; x.exp_done = ed;
        x.exp_fed = ef;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic v,
                         input logic [31:0] d, input logic ds);
        if (sel) begin
            start_b = st; in_valid_b = v; in_data_b = d; ds_stall_b = ds;
        end else begin
            start_a = st; in_valid_a = v; in_data_a = d; ds_stall_a = ds;
        end
    endtask

    task automatic sample(input bit sel, output logic rdy, output logic stl,
                          output logic [31:0] kd, output logic dn,
                          output logic [15:0] fc);
        if (sel) begin
            rdy = in_ready_b; stl = stall_b; kd = kd_vin_b; dn = done_b; fc = fed_cnt_b;
        end else begin
            rdy = in_ready_a; stl = stall_a; kd = kd_vin_a; dn = done_a; fc = fed_cnt_a;
        end
    endtask

    // Feeds words base+nxt0..base+n and checks output order until done
    task automatic run(input bit sel, input int unsigned n, input bit rnd,
                       input bit do_start, input int unsigned nxt0,
                       input int unsigned got0, input logic [31:0] base,
                       input string tag);
        int unsigned nxt;
        int unsigned got;
        bit          acc;
        bit          fin;
        logic        rdy, stl, dn;
        logic [31:0] kd;
        logic [15:0] fc;
        nxt = nxt0;
        got = got0;
        fin = 1'b0;
        if (do_start) begin
            @(negedge clk);
            drive(sel, 1'b1, 1'b0, '0, 1'b0);
            @(posedge clk);
        end
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            drive(sel, 1'b0, nxt <= n, base + nxt,
                  rnd ? ($urandom_range(1) == 1) : 1'b0);
            #1;
            sample(sel, rdy, stl, kd, dn, fc);
            acc = (nxt <= n) && rdy;
            if (dn) begin
                fin = 1'b1;
                check({tag, "_fed_cnt_at_done"}, fc, n);
                check({tag, "_words_seen"}, got, n);
            end else if (!stl) begin
                check({tag, "_kd_order"}, kd, base + got + 1);
                got++;
            end else begin
                check({tag, "_kd_zero_on_stall"}, kd, 0);
            end
            @(posedge clk);
            if (acc) nxt++;
        end
        if (!fin) check({tag, "_timeout_no_done"}, 0, 1);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, '0, 1'b0);
        #1;
        sample(sel, rdy, stl, kd, dn, fc);
        check({tag, "_done_single_pulse"}, dn, 0);
        check({tag, "_fed_cnt_hold"}, fc, n);
    endtask

    int unsigned nxt, got;
    bit          acc;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Directed vectors: outputs observed before the edge of each row
        tbl[0]  = mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 1, 1, 1, 0,  0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 0, 1, 1, 0,  1, 1, 0, 0, 0);
        tbl[7]  = mk(1, 0, 1, 2, 0,  1, 0, 1, 0, 0);
        tbl[8]  = mk(1, 0, 1, 3, 0,  1, 0, 2, 0, 1);
        tbl[9]  = mk(1, 0, 1, 4, 0,  1, 0, 3, 0, 2);
        tbl[10] = mk(1, 1, 1, 5, 0,  1, 0, 4, 0, 3);
        tbl[11] = mk(1, 0, 1, 6, 0,  1, 0, 5, 0, 4);
        tbl[12] = mk(1, 0, 1, 7, 0,  1, 0, 6, 0, 5);
        tbl[13] = mk(1, 0, 1, 8, 0,  1, 0, 7, 0, 6);
        tbl[14] = mk(1, 0, 1, 9, 0,  0, 0, 8, 0, 7);
        tbl[15] = mk(1, 1, 1, 9, 0,  0, 1, 0, 1, 8);
        tbl[16] = mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 8);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst        = tbl[i].rst_n;
            start_a    = tbl[i].start;
            in_valid_a = tbl[i].in_valid;
            in_data_a  = tbl[i].in_data;
            ds_stall_a = tbl[i].ds_stall;
            #1;
            check($sformatf("tbl%0d_in_ready", i), in_ready_a, tbl[i].exp_ready);
            check($sformatf("tbl%0d_stall", i),    stall_a,    tbl[i].exp_stall);
            check($sformatf("tbl%0d_kd_vin", i),   kd_vin_a,   tbl[i].exp_kd);
            check($sformatf("tbl%0d_done", i),     done_a,     tbl[i].exp_done);
            check($sformatf("tbl%0d_fed_cnt", i),  fed_cnt_a,  tbl[i].exp_fed);
        end

        // Back-pressure: fill the 4-deep FIFO while ds_stall holds
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        @(posedge clk);
        nxt = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b1, nxt, 1'b1);
            #1;
            check("bp_stall_held", stall_a, 1);
            check("bp_kd_zero", kd_vin_a, 0);
            acc = in_ready_a;
            @(posedge clk);
            if (acc) nxt++;
        end
        check("bp_accepts_when_full", nxt - 1, 4);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, nxt, 1'b0);
        #1;
        check("bp_full_pop_ready_low", in_ready_a, 0);
        check("bp_first_pop_stall", stall_a, 0);
        check("bp_first_pop_word", kd_vin_a, 1);
        @(posedge clk);
        run(1'b0, 8, 1'b0, 1'b0, nxt, 1, 32'h0, "bp");

        // Mid-run reset after three words are fed
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
        @(posedge clk);
        nxt = 1;
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b1, 32'h40 + nxt, 1'b0);
            #1;
            acc = in_ready_a;
            if (!stall_a) got++;
            @(posedge clk);
            if (acc) nxt++;
        end
        check("mid_rst_three_fed", got, 3);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", stall_a, 1);
        check("mid_rst_fed_cnt", fed_cnt_a, 0);
        check("mid_rst_in_ready", in_ready_a, 0);
        check("mid_rst_kd_vin", kd_vin_a, 0);
        check("mid_rst_done", done_a, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("mid_rst_no_done", done_a, 0);
        end
        run(1'b0, 8, 1'b0, 1'b1, 1, 0, 32'h100, "after_rst");

        // Random back-pressure on both depths; DEPTH=16 with 20 words wraps
        run(1'b0, 8, 1'b1, 1'b1, 1, 0, 32'h55, "a_rnd");
        run(1'b1, 20, 1'b1, 1'b1, 1, 0, 32'hA000, "wrap16");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
